// File: rtl/btn_conditioner.sv
// Button conditioning for movement control: per-bit 2-FF synchroniser,
// 4-state debounce FSM, registered level plus single-cycle press/release pulses.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             s;

    assign s = sync2_reg[gi];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        level_reg   <= level_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    // Counter restarts from zero on every entry to a WAIT state and
    // saturates at CNT_MAX, where the new level is accepted.
    always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      level_next   = level_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_next = PRESS_WAIT;
            cnt_next   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_next = IDLE;
          end else if (cnt_reg == CNT_MAX) begin
            state_next = PRESSED;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_next = RELEASE_WAIT;
            cnt_next   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_next = PRESSED;
          end else if (cnt_reg == CNT_MAX) begin
            state_next   = IDLE;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          level_next = 1'b0;
        end
      endcase
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
  end

endmodule
